// File: rtl/edit_ctrl.sv
// rtl/edit_ctrl.sv - RUN/EDIT controller for clock/calendar field editing
// Define EDIT_CTRL_AUTO_REPEAT_EN to enable auto-repeat on held up/down buttons.
module edit_ctrl #(
  parameter int TIMEOUT_S   = 30,
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1Hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] select_item,
  output logic       run_en,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_S + 1);

  typedef enum logic {RUN, EDIT} state_t;

  state_t        state;
  logic          prev_mode, prev_up, prev_down;
  logic [TW-1:0] idle_cnt;
  logic          mode_press, up_press, down_press, timeout;
  logic          rep_up, rep_down, rep_fire;

  assign mode_press = btn_mode & ~prev_mode;
  assign up_press   = btn_up & ~prev_up;
  assign down_press = btn_down & ~prev_down;
  assign timeout    = tick_1Hz && (idle_cnt == TW'(TIMEOUT_S - 1));

`ifdef EDIT_CTRL_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rep_started, rep_held;
  logic [RW-1:0] rep_cnt;

  assign rep_held = (rep_up & btn_up) | (rep_down & btn_down);
  assign rep_fire = rep_held &&
                    (rep_cnt == (rep_started ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DLY - 1)));

  // Repeat tracks the last single-direction press; anything that leaves the field idles it.
  always_ff @(posedge clk) begin
    if (rst || state != EDIT || timeout || mode_press || (up_press && down_press)) begin
      rep_up      <= 1'b0;
      rep_down    <= 1'b0;
      rep_started <= 1'b0;
      rep_cnt     <= '0;
    end else if (up_press || down_press) begin
      rep_up      <= up_press;
      rep_down    <= down_press;
      rep_started <= 1'b0;
      rep_cnt     <= '0;
    end else if (rep_held) begin
      if (rep_fire) begin
        rep_cnt     <= '0;
        rep_started <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end else begin
      rep_up      <= 1'b0;
      rep_down    <= 1'b0;
      rep_started <= 1'b0;
      rep_cnt     <= '0;
    end
  end
`else
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      select_item <= 3'd0;
      run_en      <= 1'b1;
      up_pulse    <= 1'b0;
      down_pulse  <= 1'b0;
      blink       <= 1'b0;
      idle_cnt    <= '0;
      // Held-through-reset buttons must be released before they count as a press.
      prev_mode   <= 1'b1;
      prev_up     <= 1'b1;
      prev_down   <= 1'b1;
    end else begin
      prev_mode  <= btn_mode;
      prev_up    <= btn_up;
      prev_down  <= btn_down;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      case (state)
        RUN: begin
          select_item <= 3'd0;
          run_en      <= 1'b1;
          blink       <= 1'b0;
          idle_cnt    <= '0;
          if (mode_press) begin
            state       <= EDIT;
            select_item <= 3'd1;
            run_en      <= 1'b0;
            blink       <= 1'b1;
          end
        end
        EDIT: begin
          if (tick_1Hz) begin
            idle_cnt <= idle_cnt + TW'(1);
            blink    <= ~blink;
          end
          if (timeout) begin
            state       <= RUN;
            select_item <= 3'd0;
            run_en      <= 1'b1;
            blink       <= 1'b0;
            idle_cnt    <= '0;
          end else if (mode_press) begin
            idle_cnt <= '0;
            if (select_item == 3'd5) begin
              state       <= RUN;
              select_item <= 3'd0;
              run_en      <= 1'b1;
              blink       <= 1'b0;
            end else begin
              select_item <= select_item + 3'd1;
              blink       <= 1'b1;
            end
          end else if (up_press || down_press) begin
            idle_cnt   <= '0;
            up_pulse   <= up_press & ~down_press;
            down_pulse <= down_press & ~up_press;
          end else if (rep_fire) begin
            idle_cnt   <= '0;
            up_pulse   <= rep_up;
            down_pulse <= rep_down;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_edit_ctrl.sv
// tb/tb_edit_ctrl.sv - scoreboard bench for edit_ctrl
module tb_edit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1Hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] select_item;
  logic       run_en, up_pulse, down_pulse, blink;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [2:0] sel;
    logic       run;
    logic       up;
    logic       dn;
    logic       blk;
  } exp_t;

  exp_t exp_q[$];

  edit_ctrl #(.TIMEOUT_S(3), .REPEAT_DLY(10), .REPEAT_RATE(4)) dut (
    .clk(clk), .rst(rst), .tick_1Hz(tick_1Hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .select_item(select_item), .run_en(run_en),
    .up_pulse(up_pulse), .down_pulse(down_pulse), .blink(blink)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Any change of field/run state or any pulse is an event that must match the queue head.
  initial begin : monitor
    logic [2:0] last_sel;
    logic       last_run;
    exp_t       e;
    last_sel = 3'd0;
    last_run = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_sel = select_item;
        last_run = run_en;
      end else if (select_item !== last_sel || run_en !== last_run ||
                   up_pulse === 1'b1 || down_pulse === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: cyc=%0d sel=%0d run=%0b up=%0b dn=%0b blink=%0b",
                   cyc, select_item, run_en, up_pulse, down_pulse, blink);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.sel !== select_item || e.run !== run_en ||
              e.up !== up_pulse || e.dn !== down_pulse || e.blk !== blink) begin
            n_bad++;
            $display("FAIL event: got cyc=%0d sel=%0d run=%0b up=%0b dn=%0b blink=%0b, expected cyc=%0d sel=%0d run=%0b up=%0b dn=%0b blink=%0b",
                     cyc, select_item, run_en, up_pulse, down_pulse, blink,
                     e.cyc, e.sel, e.run, e.up, e.dn, e.blk);
          end
        end
        last_sel = select_item;
        last_run = run_en;
      end
    end
  end

  task automatic push(input int c, input logic [2:0] s, input logic r,
                      input logic u, input logic d, input logic b);
    exp_t e;
    e.cyc = c; e.sel = s; e.run = r; e.up = u; e.dn = d; e.blk = b;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic mode_press(input logic [2:0] s, input logic r, input logic b);
    @(negedge clk);
    btn_mode = 1'b1;
    push(cyc + 1, s, r, 1'b0, 1'b0, b);
    @(negedge clk);
    btn_mode = 1'b0;
    idle(2);
  endtask

  task automatic tick();
    @(negedge clk);
    tick_1Hz = 1'b1;
    @(negedge clk);
    tick_1Hz = 1'b0;
    idle(2);
  endtask

  initial begin
    int c;
    idle(3);
    rst = 1'b0;
    idle(2);
    check("reset_sel", select_item, 0);
    check("reset_run_en", run_en, 1);
    check("reset_up", up_pulse, 0);
    check("reset_down", down_pulse, 0);
    check("reset_blink", blink, 0);

    // full mode cycle
    mode_press(3'd1, 1'b0, 1'b1);
    mode_press(3'd2, 1'b0, 1'b1);
    mode_press(3'd3, 1'b0, 1'b1);
    mode_press(3'd4, 1'b0, 1'b1);
    mode_press(3'd5, 1'b0, 1'b1);
    mode_press(3'd0, 1'b1, 1'b0);

    // up held 30 cycles at month field
    mode_press(3'd1, 1'b0, 1'b1);
    mode_press(3'd2, 1'b0, 1'b1);
    mode_press(3'd3, 1'b0, 1'b1);
    mode_press(3'd4, 1'b0, 1'b1);
    @(negedge clk);
    btn_up = 1'b1;
    c = cyc;
    push(c + 1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef EDIT_CTRL_AUTO_REPEAT_EN
    push(c + 11, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    push(c + 15, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    push(c + 19, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    push(c + 23, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    push(c + 27, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
`endif
    idle(30);
    btn_up = 1'b0;
    idle(3);
    @(negedge clk);
    btn_down = 1'b1;
    push(cyc + 1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    btn_down = 1'b0;
    idle(2);

    // simultaneous up+down: no pulse, no repeat
    @(negedge clk);
    btn_up = 1'b1;
    btn_down = 1'b1;
    idle(15);
    btn_up = 1'b0;
    btn_down = 1'b0;
    idle(2);
    mode_press(3'd5, 1'b0, 1'b1);
    mode_press(3'd0, 1'b1, 1'b0);

    // up in RUN is ignored
    @(negedge clk);
    btn_up = 1'b1;
    @(negedge clk);
    btn_up = 1'b0;
    idle(2);

    // mode+up same cycle: mode wins
    mode_press(3'd1, 1'b0, 1'b1);
    @(negedge clk);
    btn_mode = 1'b1;
    btn_up = 1'b1;
    push(cyc + 1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    btn_mode = 1'b0;
    btn_up = 1'b0;
    idle(2);
    mode_press(3'd3, 1'b0, 1'b1);
    mode_press(3'd4, 1'b0, 1'b1);
    mode_press(3'd5, 1'b0, 1'b1);
    mode_press(3'd0, 1'b1, 1'b0);

    // timeout after 3 idle ticks
    mode_press(3'd1, 1'b0, 1'b1);
    tick();
    check("blink_after_tick1", blink, 0);
    tick();
    check("blink_after_tick2", blink, 1);
    @(negedge clk);
    tick_1Hz = 1'b1;
    push(cyc + 1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick_1Hz = 1'b0;
    idle(2);

    // press at tick 2 restarts the inactivity count
    mode_press(3'd1, 1'b0, 1'b1);
    tick();
    @(negedge clk);
    tick_1Hz = 1'b1;
    btn_up = 1'b1;
    push(cyc + 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    tick_1Hz = 1'b0;
    btn_up = 1'b0;
    idle(2);
    tick();
    tick();
    check("edit_after_tick4", run_en, 0);
    @(negedge clk);
    tick_1Hz = 1'b1;
    push(cyc + 1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tick_1Hz = 1'b0;
    idle(2);

    // reset mid-EDIT with up held through it
    mode_press(3'd1, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    btn_up = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    check("post_reset_sel", select_item, 0);
    check("post_reset_run_en", run_en, 1);
    check("post_reset_up", up_pulse, 0);
    mode_press(3'd1, 1'b0, 1'b1);
    idle(5);
    btn_up = 1'b0;
    idle(2);
    @(negedge clk);
    btn_up = 1'b1;
    push(cyc + 1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    btn_up = 1'b0;
    idle(3);

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    check("pending_expected_events", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edit_ctrl.md
EDIT_CTRL -- requirements
Module: edit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_S, default 30: seconds of button inactivity before leaving edit mode.
REQ-002 SHALL have parameter REPEAT_DLY, default 500: clk cycles a button is held before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE, default 100: clk cycles between auto-repeat pulses.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tick_1Hz  input  1  one-clk-wide strobe, once per second.
REQ-007 SHALL have port btn_mode  input  1  debounced level, synchronous to clk.
REQ-008 SHALL have port btn_up  input  1  debounced level, synchronous to clk.
REQ-009 SHALL have port btn_down  input  1  debounced level, synchronous to clk.
REQ-010 SHALL have port select_item  output  3  field under edit: 000 none, 001 hour, 010 minute, 011 day, 100 month, 101 year.
REQ-011 SHALL have port run_en  output  1  timekeeping enable to all counters.
REQ-012 SHALL have port up_pulse  output  1  one-clk increment strobe to the selected field.
REQ-013 SHALL have port down_pulse  output  1  one-clk decrement strobe to the selected field.
REQ-014 SHALL have port blink  output  1  display blank phase for the selected field.

Function
REQ-015 SHALL implement FSM states RUN and EDIT; all outputs registered.
REQ-016 SHALL detect a press as input sampled 1 with previous sample 0; output responds in the cycle after that sample.
REQ-017 SHALL, in RUN on a mode press, enter EDIT with select_item=001.
REQ-018 SHALL, in EDIT on a mode press, advance select_item 001->010->011->100->101; from 101 return to RUN with select_item=000.
REQ-019 SHALL drive run_en=1 and select_item=000 in RUN; run_en=0 in EDIT.
REQ-020 SHALL, in EDIT, emit exactly one up_pulse per up press and one down_pulse per down press; never in RUN.
REQ-021 SHALL ignore up and down presses sampled in the same cycle (no pulse) and, in that case, leave the auto-repeat state idle.
REQ-022 SHALL give a mode press priority: same-cycle up/down presses produce no pulse.
REQ-023 SHALL never assert up_pulse and down_pulse together.
REQ-024 SHALL keep an inactivity counter (width fitting TIMEOUT_S) incremented on tick_1Hz in EDIT, cleared on any press or repeat pulse and on entering EDIT.
REQ-025 SHALL, when the counter reaches TIMEOUT_S, return to RUN (select_item=000, run_en=1); a press in that same cycle is discarded.
REQ-026 SHALL toggle blink on each tick_1Hz in EDIT, set blink=1 on entering EDIT or changing field, hold blink=0 in RUN.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, force RUN, select_item=000, run_en=1, up_pulse=0, down_pulse=0, blink=0, counters 0.
REQ-028 SHALL reset the previous-sample registers to 1 so a button held through reset fires only after release and re-press.
REQ-029 SHALL let reset mid-EDIT or mid-repeat abort immediately with no trailing pulse.

Configuration
REQ-030 SHALL, with macro EDIT_CTRL_AUTO_REPEAT_EN defined, after up or down held REPEAT_DLY cycles past its press, emit one pulse of that direction every REPEAT_RATE cycles while held; release stops repeat next cycle.
REQ-031 SHALL, without EDIT_CTRL_AUTO_REPEAT_EN, omit repeat counters; holding yields only the single press pulse.

Verification
REQ-032 SHALL cover: reset, then 6 mode presses -> select_item 001,010,011,100,101,000; run_en 0 after first, 1 after sixth.
REQ-033 SHALL cover: select_item=100, one up press -> one up_pulse, 1 cycle wide, cycle after press sample.
REQ-034 SHALL cover: up and down rising same cycle in EDIT -> no pulse; mode+up same cycle at 001 -> select_item=010, no up_pulse.
REQ-035 SHALL cover: TIMEOUT_S=3, enter EDIT, 3 tick_1Hz with no press -> RUN, select_item=000 after third tick; press at tick 2 -> RUN after tick 5.
REQ-036 SHALL cover (macro defined, REPEAT_DLY=10, REPEAT_RATE=4): hold up 30 cycles in EDIT -> pulses at press+1, +11, +15, +19, +23, +27, none after release.
REQ-037 SHALL cover: btn_up held across rst deassertion -> no pulse until released and pressed again.
